// File: rtl/mem_arbiter_if.sv
// Bundles both requester ports and the block-RAM port of mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;

  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output ack0, ack1, rdata, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  ack0, ack1, rdata, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the UART loader (0) and CPU (1) shared access
// to a single-port block RAM with 1-cycle read latency; one access per 4 cycles.
//
// state  | meaning
// IDLE   | waiting for a request; grant decided at the closing edge
// ACCESS | mem_en high, RAM performs the access at the closing edge
// RESP   | RAM read data available; captured at the closing edge, ack set
// DONE   | ack pulse to the granted requester
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic                  txn_we_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  grant_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_d = bus.req1;
    if (bus.req0 && bus.req1) begin
      grant_d = ~last_grant_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      txn_we_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            grant_q     <= grant_d;
            txn_we_q    <= grant_d ? bus.we1 : bus.we0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_d ? bus.we1 : bus.we0;
            mem_addr_q  <= grant_d ? bus.addr1 : bus.addr0;
            mem_wdata_q <= grant_d ? bus.wdata1 : bus.wdata0;
            state_q     <= ACCESS;
          end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
          end
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= RESP;
        end
        RESP: begin
          if (!txn_we_q) begin
            rdata_q <= bus.mem_rdata;
          end
          ack0_q       <= ~grant_q;
          ack1_q       <= grant_q;
          last_grant_q <= grant_q;
          state_q      <= DONE;
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 4K x 8 registered-read RAM.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] ram [4096];

  mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();

  mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
  end

  always @(posedge CLK) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic tk();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic r, input logic we,
                         input logic [11:0] a, input logic [7:0] d);
    if (n == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // Single uncontended transaction, starting and ending in an IDLE cycle.
  task automatic txn(input int n, input logic we, input logic [11:0] a,
                     input logic [7:0] d, input logic [7:0] rd);
    set_req(n, 1'b1, we, a, d);
    tk();
    chk("grant_busy", bus.busy, 1);
    chk("grant_en", bus.mem_en, 1);
    chk("grant_we", bus.mem_we, we);
    chk("grant_addr", bus.mem_addr, a);
    chk("grant_wdata", bus.mem_wdata, d);
    tk();
    chk("access_en", bus.mem_en, 0);
    chk("access_we", bus.mem_we, 0);
    chk("access_acks", {bus.ack0, bus.ack1}, 0);
    tk();
    if (!we) exp_rdata = rd;
    chk("ack_mine", n ? bus.ack1 : bus.ack0, 1);
    chk("ack_other", n ? bus.ack0 : bus.ack1, 0);
    chk("ack_rdata", bus.rdata, exp_rdata);
    set_req(n, 1'b0, we, a, d);
    tk();
    chk("done_busy", bus.busy, 0);
    chk("done_acks", {bus.ack0, bus.ack1}, 0);
  endtask

  // Both requests held; grants must alternate starting with requester 0.
  task automatic contend(input int ntx, input logic [7:0] rd0, input logic [7:0] rd1);
    logic g;
    for (int k = 0; k < 4 * ntx; k++) begin
      tk();
      g = ((k / 4) % 2) != 0;
      case (k % 4)
        0: begin
          chk("rr_addr", bus.mem_addr, g ? bus.addr1 : bus.addr0);
          chk("rr_we", bus.mem_we, g ? bus.we1 : bus.we0);
          chk("rr_busy", bus.busy, 1);
        end
        2: begin
          if (!(g ? bus.we1 : bus.we0)) exp_rdata = g ? rd1 : rd0;
          chk("rr_ack0", bus.ack0, !g);
          chk("rr_ack1", bus.ack1, g);
          chk("rr_rdata", bus.rdata, exp_rdata);
        end
        3: chk("rr_idle", bus.busy, 0);
        default: chk("rr_acks_low", {bus.ack0, bus.ack1}, 0);
      endcase
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  initial begin
    set_req(0, 1'b0, 1'b0, 12'h000, 8'h00);
    set_req(1, 1'b0, 1'b0, 12'h000, 8'h00);

    // Reset values
    tk(); tk();
    chk("rst_busy", bus.busy, 0);
    chk("rst_acks", {bus.ack0, bus.ack1}, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    RST = 1'b0;
    tk();

    // Requester 1 write then read back
    txn(1, 1'b1, 12'h123, 8'hA5, 8'h00);
    txn(1, 1'b0, 12'h123, 8'h5A, 8'hA5);

    // Simultaneous requests after reset: requester 0 first
    RST = 1'b1; tk(); RST = 1'b0;
    exp_rdata = 8'h00;
    chk("rst2_rdata", bus.rdata, 0);
    set_req(0, 1'b1, 1'b0, 12'h000, 8'h77);
    set_req(1, 1'b1, 1'b1, 12'hFFF, 8'h3C);
    contend(2, 8'h00, 8'h00);
    txn(1, 1'b0, 12'hFFF, 8'h00, 8'h3C);

    // Sustained contention, 8 alternating reads
    set_req(0, 1'b1, 1'b0, 12'h123, 8'h00);
    set_req(1, 1'b1, 1'b0, 12'hFFF, 8'h00);
    contend(8, 8'hA5, 8'h3C);
    tk();
    chk("rr_quiet", bus.busy, 0);

    // Address boundaries from requester 0
    txn(0, 1'b1, 12'h000, 8'h11, 8'h00);
    txn(0, 1'b1, 12'hFFF, 8'h22, 8'h00);
    txn(0, 1'b0, 12'h000, 8'h00, 8'h11);
    txn(0, 1'b0, 12'hFFF, 8'h00, 8'h22);

    // Reset during ACCESS of a requester-1 read
    set_req(1, 1'b1, 1'b0, 12'h123, 8'h00);
    tk();
    chk("mid_access_en", bus.mem_en, 1);
    RST = 1'b1;
    tk();
    RST = 1'b0;
    bus.req1 = 1'b0;
    exp_rdata = 8'h00;
    chk("mid_busy", bus.busy, 0);
    chk("mid_en", bus.mem_en, 0);
    chk("mid_rdata", bus.rdata, 0);
    chk("mid_ack1", bus.ack1, 0);
    for (int k = 0; k < 3; k++) begin
      tk();
      chk("mid_no_ack", {bus.ack0, bus.ack1, bus.busy}, 0);
    end
    txn(1, 1'b0, 12'h123, 8'h00, 8'hA5);

    // Held request 0: ack every 4 cycles, busy low one cycle between
    set_req(0, 1'b1, 1'b0, 12'h000, 8'h00);
    for (int k = 0; k < 12; k++) begin
      tk();
      chk("held_busy", bus.busy, (k % 4) != 3);
      chk("held_ack0", bus.ack0, (k % 4) == 2);
      chk("held_ack1", bus.ack1, 0);
      if ((k % 4) == 2) chk("held_rdata", bus.rdata, 8'h11);
    end
    bus.req0 = 1'b0;
    tk();
    chk("held_end_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter for the SoC's single-port 4K x 8 block RAM (12-bit address space).
- Requester 0 is the UART monitor/loader; requester 1 is the CPU core.
- The block serialises their accesses with round-robin fairness and drives the RAM port from registered signals.
- It returns read data and a one-cycle acknowledge to the granted requester only.

Parameters:
ADDR_WIDTH, 12, RAM word address width
DATA_WIDTH, 8, RAM data width

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous active-high reset
req0  input  1  requester 0 access request (level, held until ack0)
we0  input  1  requester 0 write enable (1=write, 0=read)
addr0  input  ADDR_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 write data
ack0  output  1  requester 0 acknowledge, one-cycle pulse
req1, we1, addr1, wdata1, ack1  as above for requester 1
rdata  output  DATA_WIDTH  read data, valid in the ack cycle; shared by both requesters
busy  output  1  high whenever state != IDLE
mem_en  output  1  RAM port enable (registered)
mem_we  output  1  RAM write enable (registered)
mem_addr  output  ADDR_WIDTH  RAM address (registered)
mem_wdata  output  DATA_WIDTH  RAM write data (registered)
mem_rdata  input  DATA_WIDTH  RAM read data; RAM has 1-cycle registered read latency

Behaviour:
- Reset: state=IDLE, ack0=ack1=0, rdata=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, last_grant=1 (requester 0 wins the first tie), busy=0.
- Requesters hold req/we/addr/wdata stable from assertion until their ack cycle. The arbiter samples them only at the grant edge.
- States: IDLE -> ACCESS -> RESP -> DONE -> IDLE.
- IDLE, only reqN high at an edge:
  - grant=N.
  - mem_addr<=addrN, mem_wdata<=wdataN, mem_we<=weN, mem_en<=1.
  - next state ACCESS.
- IDLE, both requests high: grant the requester != last_grant, then proceed as above.
- IDLE, no request: hold; mem_en=0, mem_we=0.
- ACCESS: the RAM performs the access at the closing edge. mem_en<=0 and mem_we<=0 at that edge (one-cycle enable). Next state RESP.
- RESP: at the closing edge, rdata<=mem_rdata for reads; rdata is unchanged for writes. ack[grant]<=1, last_grant<=grant, next state DONE.
- DONE: ack[grant] is high for exactly this cycle. At the closing edge ack<=0 and next state IDLE.
- Latency: req seen at edge E0 gives ack high during the cycle after E2, i.e. 3 cycles from the request edge to ack. A full transaction occupies 4 cycles; maximum throughput is 1 access per 4 cycles.
- Requester duty: drop reqN in the cycle following ack. A reqN still high in IDLE is treated as a new request.
- The non-granted requester's req is ignored until IDLE. It is never dropped, only delayed by at most one transaction (round-robin guarantee).
- Only one of ack0/ack1 is ever high. It never asserts for a requester whose req was low at the grant edge.
- Request withdrawn before ack (protocol violation): the transaction still completes and ack still pulses.
- Addresses are used verbatim; there is no wrap or range check (the full 2^ADDR_WIDTH space is valid).
- RST high in any cycle: all registers return to reset values at that edge and any in-flight transaction is abandoned with no ack.
- A RAM write whose mem_we was already high when that reset edge arrives completes in the RAM. No further write is issued.
- RST has priority over every request sampled at the same edge.

Test Plan:
- Single write/read, requester 1: write addr1=0x123, wdata1=0xA5; ack1 pulses 3 cycles after the req edge with mem_we=1 for 1 cycle. Then read 0x123: ack1 pulses, rdata=0xA5, ack0 stays 0.
- Simultaneous requests after reset: req0 (read 0x000) and req1 (write 0xFFF=0x3C) both high. Required order: requester 0 acked first, requester 1 acked 4 cycles later. A read of 0xFFF afterwards returns 0x3C.
- Sustained contention: both reqs re-asserted immediately after each ack for 8 transactions. Grants strictly alternate 0,1,0,1,...; each ack is spaced exactly 4 cycles apart.
- Address boundaries: write 0x000=0x11 and 0xFFF=0x22 from requester 0, then read both back. Required: 0x11 and 0x22, with no aliasing.
- Reset mid-operation: assert RST for 1 cycle during ACCESS of a requester-1 read. Required: no ack1, busy=0 and mem_en=0 the next cycle, rdata=0. A subsequent request is serviced normally with ack in 3 cycles.
- Held request: keep req0 high continuously with no other traffic. Required: ack0 every 4 cycles (re-accepted in IDLE), busy low exactly one cycle between transactions.
